// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory bus arbiter: FSM state encoding and port indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

endpackage

// File: rtl/dmem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the port that was not granted last.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_idx,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        gnt_idx = PORT_CPU;
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end else if (req[1]) begin
            gnt_idx = PORT_IO;
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares one data memory between the CPU port (0) and the IO/DMA port (1).
// Optional macro DMEM_ARB_LOCK_EN adds p0_lock/p1_lock for back-to-back locked transfers.
module dmem_bus_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int ACC_CYC = 1
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_wr,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          p0_lock,
    input  logic          p1_lock,
`endif
    output logic          dm_cs,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [AW-1:0] dm_address,
    output logic [DW-1:0] dm_d_in,
    input  logic [DW-1:0] dm_out,
    output logic          busy
);

    localparam int             CNT_W    = $clog2(ACC_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

    arb_state_t       r_state, w_state_nxt;
    logic             r_last_gnt, r_gnt, r_wr;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata, r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic             r_p0_ack, r_p1_ack, r_dm_cs, r_dm_rd, r_dm_wr;
    logic [DW-1:0]    r_p0_rdata, r_p1_rdata, r_dm_d_in;
    logic [AW-1:0]    r_dm_address;

    logic             w_any_req, w_rr_idx, w_grant, w_sel, w_acc_last, w_wr_nxt;
    logic             w_go_acc, w_go_resp;
    logic [AW-1:0]    w_addr_nxt;
    logic [DW-1:0]    w_wdata_nxt, w_rdata_nxt;

    rr_arb2 u_rr_arb2 (
        .req      ({p1_req, p0_req}),
        .last_gnt (r_last_gnt),
        .gnt_idx  (w_rr_idx),
        .any_req  (w_any_req)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = w_rr_idx;
        w_acc_last  = (r_state == ST_ACCESS) && (r_cnt == CNT_LAST);
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_acc_last) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
`ifdef DMEM_ARB_LOCK_EN
                // Locked owner re-enters ACCESS directly; last_gnt is left alone.
                if ((r_gnt == PORT_IO) ? (p1_lock && p1_req) : (p0_lock && p0_req)) begin
                    w_grant     = 1'b1;
                    w_sel       = r_gnt;
                    w_state_nxt = ST_ACCESS;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        if (w_grant) begin
            w_wr_nxt    = w_sel ? p1_wr    : p0_wr;
            w_addr_nxt  = w_sel ? p1_addr  : p0_addr;
            w_wdata_nxt = w_sel ? p1_wdata : p0_wdata;
        end
        w_rdata_nxt = (w_acc_last && !r_wr) ? dm_out : r_rdata;
    end

    assign w_go_acc  = (w_state_nxt == ST_ACCESS);
    assign w_go_resp = (w_state_nxt == ST_RESP);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_gnt   <= PORT_IO;
            r_gnt        <= PORT_CPU;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_dm_cs      <= 1'b0;
            r_dm_rd      <= 1'b0;
            r_dm_wr      <= 1'b0;
            r_dm_address <= '0;
            r_dm_d_in    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt   <= w_sel;
                r_wr    <= w_wr_nxt;
                r_addr  <= w_addr_nxt;
                r_wdata <= w_wdata_nxt;
                r_cnt   <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_grant && (r_state == ST_IDLE)) r_last_gnt <= w_sel;
            r_rdata <= w_rdata_nxt;

            // Outputs are registered from the next state so they align with it.
            r_dm_cs      <= w_go_acc;
            r_dm_rd      <= w_go_acc && !w_wr_nxt;
            r_dm_wr      <= w_go_acc && w_wr_nxt;
            r_dm_address <= w_go_acc ? w_addr_nxt : '0;
            r_dm_d_in    <= (w_go_acc && w_wr_nxt) ? w_wdata_nxt : '0;
            r_p0_ack     <= w_go_resp && (r_gnt == PORT_CPU);
            r_p1_ack     <= w_go_resp && (r_gnt != PORT_CPU);
            r_p0_rdata   <= (w_go_resp && (r_gnt == PORT_CPU) && !r_wr) ? w_rdata_nxt : '0;
            r_p1_rdata   <= (w_go_resp && (r_gnt != PORT_CPU) && !r_wr) ? w_rdata_nxt : '0;
        end
    end

    assign p0_ack     = r_p0_ack;
    assign p1_ack     = r_p1_ack;
    assign p0_rdata   = r_p0_rdata;
    assign p1_rdata   = r_p1_rdata;
    assign dm_cs      = r_dm_cs;
    assign dm_rd      = r_dm_rd;
    assign dm_wr      = r_dm_wr;
    assign dm_address = r_dm_address;
    assign dm_d_in    = r_dm_d_in;
    assign busy       = (r_state != ST_IDLE);

endmodule
